mem_port_arbiter: RTL

- Shares the single LC-3b memory port (mem_read/mem_write/mem_resp, 16-bit address/data, 2-bit byte enable) between two requesters: an instruction-fetch port (read-only) and a data port (read/write).
- Sits between the processor's fetch/data sequencing and the memory model. It replaces the direct control/datapath-to-memory connection once fetch and load/store are split.
- Three-state FSM with round-robin tie-break and a registered memory-side request.

---
 rtl/mem_port_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single LC-3b memory port: a read-only fetch
// port and a read/write data port. Ties alternate, and the memory request is registered.
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [1:0]        d_byte_enable,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        mem_byte_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t state_reg;
    logic   last_grant_reg;
    logic   i_req;
    logic   d_req;
    logic   grant_i;
    logic   grant_d;

    assign i_req   = i_read;
    assign d_req   = d_read | d_write;
    // On a tie the side that did not win last time goes first.
    assign grant_i = i_req & (~d_req | (last_grant_reg == GRANT_D));
    assign grant_d = d_req & ~grant_i;

    assign i_resp  = (state_reg == I_BUSY) & mem_resp;
    assign d_resp  = (state_reg == D_BUSY) & mem_resp;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            last_grant_reg  <= GRANT_D;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= 2'b11;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_i) begin
                        state_reg       <= I_BUSY;
                        last_grant_reg  <= GRANT_I;
                        mem_read        <= 1'b1;
                        mem_write       <= 1'b0;
                        mem_address     <= i_address;
                        mem_wdata       <= '0;
                        mem_byte_enable <= 2'b11;
                    end else if (grant_d) begin
                        // A simultaneous read and write is treated as a write.
                        state_reg       <= D_BUSY;
                        last_grant_reg  <= GRANT_D;
                        mem_read        <= d_read & ~d_write;
                        mem_write       <= d_write;
                        mem_address     <= d_address;
                        mem_wdata       <= d_wdata;
                        mem_byte_enable <= d_byte_enable;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (mem_resp) begin
                        state_reg <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
